// File: rtl/note_player.sv
// Note player: consumes note/duration strobes from the song reader, times each
// note in beats derived from an internal prescaler, and gates the sounding output.
module note_player #(
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6,
    parameter int BEAT_DIV       = 1000,
    parameter int GAP_CYCLES     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      new_note,
    input  logic [NOTE_WIDTH-1:0]     note,
    input  logic [DURATION_WIDTH-1:0] duration,
    output logic                      note_done,
    output logic                      busy,
    output logic [NOTE_WIDTH-1:0]     note_out,
    output logic                      sounding,
    output logic                      beat
);

    // Wide enough to hold BEAT_DIV itself, so a zero gap never matches
    localparam int PW = $clog2(BEAT_DIV + 1);
    localparam logic [PW-1:0] BEAT_LAST = PW'(BEAT_DIV - 1);
    localparam logic [PW-1:0] GAP_START = PW'(BEAT_DIV - GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [PW-1:0]             prescale, prescale_next;
    logic [DURATION_WIDTH-1:0] beats_left, beats_next;
    logic [NOTE_WIDTH-1:0]     note_next;
    logic                      beat_edge;
    logic                      in_gap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prescale   <= '0;
            beats_left <= '0;
            note_out   <= '0;
            note_done  <= 1'b0;
        end else begin
            state      <= state_next;
            prescale   <= prescale_next;
            beats_left <= beats_next;
            note_out   <= note_next;
            note_done  <= (state_next == DONE);
        end
    end

    // A new strobe always wins, so it both starts from idle and preempts a note
    always_comb begin
        state_next    = state;
        prescale_next = prescale;
        beats_next    = beats_left;
        note_next     = note_out;
        beat_edge     = (state == PLAYING) && play && (prescale == BEAT_LAST);

        case (state)
            IDLE: state_next = IDLE;
            DONE: state_next = IDLE;
            PLAYING: begin
                if (play) begin
                    if (beat_edge) begin
                        prescale_next = '0;
                        if (beats_left != '0) begin
                            beats_next = beats_left - 1'b1;
                        end
                        if (beats_left == DURATION_WIDTH'(1)) begin
                            state_next = DONE;
                        end
                    end else begin
                        prescale_next = prescale + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (new_note) begin
            note_next     = note;
            beats_next    = duration;
            prescale_next = '0;
            state_next    = (duration != '0) ? PLAYING : DONE;
        end
    end

    assign in_gap   = (beats_left == DURATION_WIDTH'(1)) && (prescale >= GAP_START);
    assign busy     = (state == PLAYING);
    assign beat     = beat_edge;
    assign sounding = busy && (note_out != '0) && !in_gap;

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player: an elapsed-cycle reference model
// predicts note_done events and per-cycle gate/beat outputs.
module tb_note_player;

    localparam int NW  = 6;
    localparam int DW  = 6;
    localparam int BD  = 4;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic          new_note;
    logic [NW-1:0] note;
    logic [DW-1:0] duration;
    logic          note_done;
    logic          busy;
    logic [NW-1:0] note_out;
    logic          sounding;
    logic          beat;

    note_player #(
        .NOTE_WIDTH(NW), .DURATION_WIDTH(DW), .BEAT_DIV(BD), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .play(play), .new_note(new_note),
        .note(note), .duration(duration), .note_done(note_done), .busy(busy),
        .note_out(note_out), .sounding(sounding), .beat(beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NW-1:0] code;
    } done_t;

    done_t         exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            m_cyc    = 0;
    bit            m_active = 1'b0;
    int            m_elapsed = 0;
    int            m_total   = 0;
    logic [NW-1:0] m_note    = '0;

    // Reference model: a note lasts duration*BD played cycles, counted from the load
    always @(posedge clk) begin
        m_cyc++;
        if (reset) begin
            m_active  = 1'b0;
            m_note    = '0;
            m_elapsed = 0;
            m_total   = 0;
        end else if (new_note) begin
            m_note = note;
            if (duration == '0) begin
                m_active = 1'b0;
                exp_q.push_back('{m_cyc, note});
            end else begin
                m_active  = 1'b1;
                m_total   = int'(duration) * BD;
                m_elapsed = 0;
            end
        end else if (m_active && play) begin
            if (m_elapsed == m_total - 1) begin
                m_active = 1'b0;
                exp_q.push_back('{m_cyc, m_note});
            end else begin
                m_elapsed++;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, m_cyc, actual, expected);
        end
    endtask

    // Monitor: per-cycle gate outputs, plus scoreboard pops on each note_done
    always @(negedge clk) begin
        done_t e;
        checkOutput("busy", int'(busy), int'(m_active));
        checkOutput("beat", int'(beat),
                    int'(m_active && play && (((m_elapsed + 1) % BD) == 0)));
        checkOutput("sounding", int'(sounding),
                    int'(m_active && (m_note != '0) && (m_elapsed < m_total - GAP)));
        checkOutput("note_out", int'(note_out), int'(m_note));
        if (note_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_cycle", m_cyc, e.cyc);
                checkOutput("done_note", int'(note_out), int'(e.code));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= m_cyc) begin
            e = exp_q.pop_front();
            checkOutput("missing_done", 0, 1);
        end
    end

    task automatic applyStimulus(input bit rst, input bit p, input bit nn,
                                 input logic [NW-1:0] n, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        reset    = rst;
        play     = p;
        new_note = nn;
        note     = n;
        duration = d;
    endtask

    task automatic idleCycles(input int n, input bit p);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, p, 1'b0, '0, '0);
    endtask

    initial begin
        reset    = 1'b1;
        play     = 1'b1;
        new_note = 1'b0;
        note     = '0;
        duration = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
        idleCycles(2, 1'b1);

        applyStimulus(1'b0, 1'b1, 1'b1, 6'd12, 6'd3);
        idleCycles(15, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd5, 6'd0);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 6'd2);
        idleCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd7, 6'd2);
        idleCycles(3, 1'b1);
        idleCycles(5, 1'b0);
        idleCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd9, 6'd2);
        idleCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd3, 6'd4);
        idleCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd11, 6'd4);
        idleCycles(20, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd1, 6'd3);
        idleCycles(4, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd20, 6'd1);
        idleCycles(8, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 200) == 0, ($urandom % 8) != 0,
                          ($urandom % 12) == 0, NW'($urandom), DW'($urandom % 5));
        end
        idleCycles(40, 1'b1);

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
